// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : VGA raster timing generator. It runs free horizontal and
//                vertical counters and registers the pixel coordinates,
//                video_on and frame_start from them. Sync and video_on pass
//                through a PIPE_DLY-stage delay line so that the RGB565
//                pixel data, which arrives from a downstream pipeline, lines
//                up with the syncs at the DAC outputs.
//                Optional feature: define VGA_FRAME_CNT_EN to build a 16-bit
//                frame counter on frame_cnt. Without it frame_cnt is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned PIPE_DLY = 2
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] rgb_in,
    output logic [9:0]  vga_x,
    output logic [9:0]  vga_y,
    output logic        video_on,
    output logic        frame_start,
    output logic [15:0] vga_rgb,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [15:0] frame_cnt
);

    // Terminal counts fit 10 bits; region bounds are kept at 11 bits so a
    // bound equal to 1024 still compares correctly.
    localparam int unsigned c_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned c_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0]  c_H_LAST   = 10'(c_H_TOTAL - 1);
    localparam logic [9:0]  c_V_LAST   = 10'(c_V_TOTAL - 1);
    localparam logic [10:0] c_H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] c_V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] c_HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] c_VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic [10:0] w_h_ext;
    logic [10:0] w_v_ext;
    logic        w_active;
    logic        w_hs;
    logic        w_vs;
    logic        w_frame_begin;

    logic        r_video_on;
    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic        r_frame_start;
    logic        r_hs0;
    logic        r_vs0;

    logic        w_dly_von;
    logic        w_dly_hs;
    logic        w_dly_vs;

    logic [15:0] r_rgb;
    logic        r_vga_hs;
    logic        r_vga_vs;

    assign w_h_ext       = {1'b0, r_h_cnt};
    assign w_v_ext       = {1'b0, r_v_cnt};
    assign w_active      = (w_h_ext < c_H_ACT) && (w_v_ext < c_V_ACT);
    assign w_hs          = !((w_h_ext >= c_HS_BEG) && (w_h_ext < c_HS_END));
    assign w_vs          = !((w_v_ext >= c_VS_BEG) && (w_v_ext < c_VS_END));
    assign w_frame_begin = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);

    // Raster counters: h wraps every line, v advances only on the h wrap
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= 10'd0;
        end else if (r_h_cnt == c_H_LAST) begin
            r_h_cnt <= 10'd0;
            if (r_v_cnt == c_V_LAST) begin
                r_v_cnt <= 10'd0;
            end else begin
                r_v_cnt <= r_v_cnt + 10'd1;
            end
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    // First stage: coordinates, video_on, frame_start and raw syncs one clock after the counters
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_video_on    <= 1'b0;
            r_x           <= 10'd0;
            r_y           <= 10'd0;
            r_frame_start <= 1'b0;
            r_hs0         <= 1'b1;
            r_vs0         <= 1'b1;
        end else begin
            r_video_on    <= w_active;
            r_x           <= w_active ? r_h_cnt : 10'd0;
            r_y           <= w_active ? r_v_cnt : 10'd0;
            r_frame_start <= w_frame_begin;
            r_hs0         <= w_hs;
            r_vs0         <= w_vs;
        end
    end

    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            assign w_dly_von = r_video_on;
            assign w_dly_hs  = r_hs0;
            assign w_dly_vs  = r_vs0;
        end else begin : g_dly
            logic [PIPE_DLY-1:0] r_von_sr;
            logic [PIPE_DLY-1:0] r_hs_sr;
            logic [PIPE_DLY-1:0] r_vs_sr;

            // Delay line matching the downstream pixel pipeline; resets inactive
            always_ff @(posedge vga_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    r_von_sr <= '0;
                    r_hs_sr  <= '1;
                    r_vs_sr  <= '1;
                end else begin
                    r_von_sr[0] <= r_video_on;
                    r_hs_sr[0]  <= r_hs0;
                    r_vs_sr[0]  <= r_vs0;
                    for (int i = 1; i < int'(PIPE_DLY); i++) begin
                        r_von_sr[i] <= r_von_sr[i-1];
                        r_hs_sr[i]  <= r_hs_sr[i-1];
                        r_vs_sr[i]  <= r_vs_sr[i-1];
                    end
                end
            end

            assign w_dly_von = r_von_sr[PIPE_DLY-1];
            assign w_dly_hs  = r_hs_sr[PIPE_DLY-1];
            assign w_dly_vs  = r_vs_sr[PIPE_DLY-1];
        end
    endgenerate

    // Output register: pixel data joins its delayed syncs; blanked pixels drive black
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rgb    <= 16'd0;
            r_vga_hs <= 1'b1;
            r_vga_vs <= 1'b1;
        end else begin
            r_rgb    <= w_dly_von ? rgb_in : 16'd0;
            r_vga_hs <= w_dly_hs;
            r_vga_vs <= w_dly_vs;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // Frame counter steps on the same edge that raises frame_start
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_frame_cnt <= 16'd0;
        end else if (w_frame_begin) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`else
    assign frame_cnt = 16'd0;
`endif

    assign vga_x       = r_x;
    assign vga_y       = r_y;
    assign video_on    = r_video_on;
    assign frame_start = r_frame_start;
    assign vga_rgb     = r_rgb;
    assign vga_hs      = r_vga_hs;
    assign vga_vs      = r_vga_vs;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Directed bench for vga_timing_gen. u_sml uses a reduced
//                raster (30 x 15, PIPE_DLY=2) so whole frames are short;
//                u_def uses the default 800 x 525 raster with PIPE_DLY=0 and
//                is only run through its first line. Expected frame_cnt
//                follows VGA_FRAME_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

`ifdef VGA_FRAME_CNT_EN
    localparam bit c_FC_ON = 1'b1;
`else
    localparam bit c_FC_ON = 1'b0;
`endif

    logic        vga_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [15:0] rgb_in = 16'hF800;

    logic [9:0]  s_x, s_y, d_x, d_y;
    logic        s_von, s_fs, s_hs, s_vs;
    logic        d_von, d_fs, d_hs, d_vs;
    logic [15:0] s_rgb, s_fc, d_rgb, d_fc;

    int total = 0;
    int bad   = 0;
    int edges = 0;

    // Small raster: H 16/4/6/4 (total 30), V 8/2/2/3 (total 15), frame 450 clocks
    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
        .PIPE_DLY(2)
    ) u_sml (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .rgb_in(rgb_in),
        .vga_x(s_x), .vga_y(s_y), .video_on(s_von), .frame_start(s_fs),
        .vga_rgb(s_rgb), .vga_hs(s_hs), .vga_vs(s_vs), .frame_cnt(s_fc)
    );

    vga_timing_gen #(
        .PIPE_DLY(0)
    ) u_def (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .rgb_in(rgb_in),
        .vga_x(d_x), .vga_y(d_y), .video_on(d_von), .frame_start(d_fs),
        .vga_rgb(d_rgb), .vga_hs(d_hs), .vga_vs(d_vs), .frame_cnt(d_fc)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edges);
        end
    endtask

    // Advance to just after rising edge number tgt counted from reset release
    task automatic adv_to(input int tgt);
        while (edges < tgt) begin
            @(posedge vga_clk);
            edges++;
        end
        #1;
    endtask

    function automatic logic [15:0] fc(input int n);
        return c_FC_ON ? 16'(n) : 16'd0;
    endfunction

    initial begin
        // Reset state with the clock running
        repeat (3) @(posedge vga_clk);
        #1;
        chk("rst_x",     16'(s_x), 16'd0);
        chk("rst_y",     16'(s_y), 16'd0);
        chk("rst_von",   16'(s_von), 16'd0);
        chk("rst_fs",    16'(s_fs), 16'd0);
        chk("rst_rgb",   s_rgb, 16'd0);
        chk("rst_hs",    16'(s_hs), 16'd1);
        chk("rst_vs",    16'(s_vs), 16'd1);
        chk("rst_fc",    s_fc, 16'd0);
        chk("rst_d_hs",  16'(d_hs), 16'd1);
        chk("rst_d_rgb", d_rgb, 16'd0);

        @(negedge vga_clk);
        sys_rst_n = 1'b1;
        edges = 0;

        // Pixel n shows on video_on after edge n+1, on vga_* after edge n+4 (small)
        adv_to(1);
        chk("fs_first",  16'(s_fs), 16'd1);
        chk("von_p0",    16'(s_von), 16'd1);
        chk("x_p0",      16'(s_x), 16'd0);
        chk("y_p0",      16'(s_y), 16'd0);
        chk("rgb_e1",    s_rgb, 16'd0);
        chk("fc_f1",     s_fc, fc(1));
        chk("d_fs",      16'(d_fs), 16'd1);
        chk("d_rgb_e1",  d_rgb, 16'd0);
        adv_to(2);
        chk("fs_pulse",  16'(s_fs), 16'd0);
        chk("x_p1",      16'(s_x), 16'd1);
        chk("d_rgb_e2",  d_rgb, 16'hF800);
        adv_to(3);
        chk("rgb_e3",    s_rgb, 16'd0);
        adv_to(4);
        chk("rgb_first", s_rgb, 16'hF800);
        adv_to(16);
        chk("von_h15",   16'(s_von), 16'd1);
        chk("x_h15",     16'(s_x), 16'd15);
        adv_to(17);
        chk("von_h16",   16'(s_von), 16'd0);
        chk("x_h16",     16'(s_x), 16'd0);
        adv_to(19);
        chk("rgb_h15",   s_rgb, 16'hF800);
        adv_to(20);
        chk("rgb_h16",   s_rgb, 16'd0);
        adv_to(23);
        chk("hs_h19",    16'(s_hs), 16'd1);
        adv_to(24);
        chk("hs_h20",    16'(s_hs), 16'd0);
        chk("rgb_h20",   s_rgb, 16'd0);
        adv_to(29);
        chk("hs_h25",    16'(s_hs), 16'd0);
        adv_to(30);
        chk("hs_h26",    16'(s_hs), 16'd1);
        adv_to(31);
        chk("x_l1",      16'(s_x), 16'd0);
        chk("y_l1",      16'(s_y), 16'd1);
        chk("von_l1",    16'(s_von), 16'd1);
        chk("fs_l1",     16'(s_fs), 16'd0);
        adv_to(53);
        chk("hs2_pre",   16'(s_hs), 16'd1);
        adv_to(54);
        chk("hs2_fall",  16'(s_hs), 16'd0);
        adv_to(241);
        chk("von_v8",    16'(s_von), 16'd0);
        chk("y_v8",      16'(s_y), 16'd0);
        adv_to(303);
        chk("vs_v9",     16'(s_vs), 16'd1);
        adv_to(304);
        chk("vs_v10",    16'(s_vs), 16'd0);
        adv_to(363);
        chk("vs_v11",    16'(s_vs), 16'd0);
        adv_to(364);
        chk("vs_v12",    16'(s_vs), 16'd1);
        adv_to(450);
        chk("fs_pre2",   16'(s_fs), 16'd0);
        chk("von_last",  16'(s_von), 16'd0);
        adv_to(451);
        chk("fs_second", 16'(s_fs), 16'd1);
        chk("fc_f2",     s_fc, fc(2));
        adv_to(640);
        chk("d_x639",    16'(d_x), 16'd639);
        chk("d_von639",  16'(d_von), 16'd1);
        adv_to(641);
        chk("d_x640",    16'(d_x), 16'd0);
        chk("d_von640",  16'(d_von), 16'd0);
        adv_to(657);
        chk("d_hs_pre",  16'(d_hs), 16'd1);
        adv_to(658);
        chk("d_hs_fall", 16'(d_hs), 16'd0);
        adv_to(901);
        chk("fs_third",  16'(s_fs), 16'd1);
        chk("fc_f3",     s_fc, fc(3));
        chk("d_fc",      d_fc, fc(1));

        // Mid-frame reset while small hsync is low and default raster is active
        adv_to(1016);
        chk("pre_hs",    16'(s_hs), 16'd0);
        chk("pre_d_von", 16'(d_von), 16'd1);
        chk("pre_d_x",   16'(d_x), 16'd215);
        chk("pre_d_y",   16'(d_y), 16'd1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("ar_hs",     16'(s_hs), 16'd1);
        chk("ar_d_von",  16'(d_von), 16'd0);
        chk("ar_d_x",    16'(d_x), 16'd0);
        chk("ar_d_y",    16'(d_y), 16'd0);
        chk("ar_fc",     s_fc, 16'd0);
        @(negedge vga_clk);
        sys_rst_n = 1'b1;
        edges = 0;
        adv_to(1);
        chk("rr_fs",     16'(s_fs), 16'd1);
        chk("rr_von",    16'(s_von), 16'd1);
        chk("rr_x",      16'(s_x), 16'd0);
        chk("rr_fc",     s_fc, fc(1));
        chk("rr_d_fs",   16'(d_fs), 16'd1);
        adv_to(2);
        chk("rr_fs_end", 16'(s_fs), 16'd0);
        chk("rr_x1",     16'(s_x), 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16, meaning horizontal front porch in clocks.
REQ-003 The block SHALL have parameter H_SYNC, default 96, meaning horizontal sync width in clocks.
REQ-004 The block SHALL have parameter H_BP, default 48, meaning horizontal back porch in clocks.
REQ-005 The block SHALL have parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-006 The block SHALL have parameter V_FP, default 10, meaning vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2, meaning vertical sync width in lines.
REQ-008 The block SHALL have parameter V_BP, default 33, meaning vertical back porch in lines.
REQ-009 The block SHALL have parameter PIPE_DLY, default 2, legal range 0..7, meaning the downstream pixel-pipeline latency in clocks.
REQ-010 The block SHALL have port vga_clk, input, 1, meaning the pixel clock (25 MHz nominal); the block has this single clock.
REQ-011 The block SHALL have port sys_rst_n, input, 1, meaning asynchronous active-low reset.
REQ-012 The block SHALL have port vga_x, output, 10, meaning the current pixel column.
REQ-013 The block SHALL have port vga_y, output, 10, meaning the current pixel row.
REQ-014 The block SHALL have port video_on, output, 1, meaning the current pixel is in the active area.
REQ-015 The block SHALL have port frame_start, output, 1, meaning a one-clock pulse at pixel (0,0).
REQ-016 The block SHALL have port rgb_in, input, 16, meaning RGB565 from the display mux.
REQ-017 The block SHALL have port vga_rgb, output, 16, meaning RGB565 to the DAC.
REQ-018 The block SHALL have ports vga_hs and vga_vs, output, 1 each, meaning active-low sync.
REQ-019 The block SHALL have port frame_cnt, output, 16, meaning the frame counter (see Configuration).

Function
REQ-020 Horizontal counter h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H params, 800) and wrap to 0 every clock at H_TOTAL-1.
REQ-021 Vertical counter v_cnt SHALL increment only when h_cnt wraps, count 0..V_TOTAL-1 (525), and wrap to 0 when both counters are at terminal value.
REQ-022 Region order SHALL be active, front porch, sync, back porch; active is h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-023 video_on, vga_x and vga_y SHALL be registered from the counters: 1 clock after the counter state, video_on=active, vga_x=h_cnt and vga_y=v_cnt when active, 0 otherwise.
REQ-024 frame_start SHALL be high for exactly the clock on which video_on is high for pixel (0,0).
REQ-025 Internal hs/vs SHALL be low when h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) and v_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC) respectively.
REQ-026 hs, vs and video_on SHALL pass through a PIPE_DLY-stage shift register; with PIPE_DLY=0 they SHALL pass straight through.
REQ-027 rgb_in SHALL be sampled PIPE_DLY clocks after the video_on of its pixel.
REQ-028 vga_rgb, vga_hs and vga_vs for the same pixel SHALL appear together, registered, PIPE_DLY+1 clocks after that pixel's video_on.
REQ-029 vga_rgb SHALL be 0 whenever the delayed video_on is 0, regardless of rgb_in.
REQ-030 Counter widths SHALL be 10 bits; parameter totals above 1024 are illegal.

Reset
REQ-031 While sys_rst_n is low, outputs SHALL be: h_cnt=v_cnt=0, vga_x=vga_y=0, video_on=0, frame_start=0, vga_rgb=0, vga_hs=vga_vs=1, frame_cnt=0.
REQ-032 All delay-line stages SHALL reset to inactive (sync 1, video_on 0).
REQ-033 Reset asserted mid-frame SHALL take effect immediately; after release, counting SHALL restart at (0,0) and the first frame_start SHALL occur 1 clock after the first rising edge.

Configuration
REQ-034 With macro VGA_FRAME_CNT_EN defined, frame_cnt SHALL increment by 1, wrapping at 16'hFFFF, on the same clock that frame_start goes high.
REQ-035 Without VGA_FRAME_CNT_EN, frame_cnt SHALL be constant 0 and no counter logic SHALL be synthesized; all other behaviour SHALL be unchanged.

Verification
REQ-036 Release reset, run 2 frames -> 800 clocks between vga_hs falling edges, 420000 clocks between frame_start pulses, vga_hs low for 96 clocks, vga_vs low for 1600 clocks.
REQ-037 At h_cnt=639 -> 1 clock later vga_x=639 and video_on=1; at h_cnt=640 -> 1 clock later vga_x=0 and video_on=0.
REQ-038 PIPE_DLY=2 with rgb_in=16'hF800 constant -> first nonzero vga_rgb occurs 3 clocks after frame_start; vga_rgb=0 throughout blanking.
REQ-039 Assert reset at v_cnt=200 -> all outputs reach reset values without a clock edge; after release, frame_start occurs 1 clock later.
REQ-040 Build with VGA_FRAME_CNT_EN and run 3 frames -> frame_cnt=3; build without it -> frame_cnt=0.
REQ-041 PIPE_DLY=0 -> vga_hs falls 657 clocks after video_on rises for pixel (0,y).
